cpu_mem_arbiter: RTL and testbench

//  Downstream of the multi-cycle RV32 core: merges its instruction-fetch channel and data channel onto a single memory port.
//  One transaction in flight at a time; data has priority over instruction, with anti-starvation for fetch.

---
 rtl/cpu_bus_pkg.sv | 16 +
 rtl/cpu_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the core-to-memory bus: one-hot arbiter state codes
// and the byte-strobe width helper.
package cpu_bus_pkg;

  localparam logic [5:0] ARB_IDLE  = 6'b000001;
  localparam logic [5:0] ARB_IREQ  = 6'b000010;
  localparam logic [5:0] ARB_IRESP = 6'b000100;
  localparam logic [5:0] ARB_DWR   = 6'b001000;
  localparam logic [5:0] ARB_DRD   = 6'b010000;
  localparam logic [5:0] ARB_DRESP = 6'b100000;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Merges the core's fetch and data channels onto one memory port, one
// transaction at a time; data wins unless fetch has been starved too long.
module cpu_mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_W-1:0]               inst_addr,
  input  logic                            inst_req_valid,
  output logic                            inst_req_ready,
  output logic [DATA_W-1:0]               inst_rdata,
  output logic                            inst_rvalid,
  input  logic                            inst_rready,
  input  logic [ADDR_W-1:0]               data_addr,
  input  logic                            data_wen,
  input  logic                            data_ren,
  input  logic [DATA_W-1:0]               data_wdata,
  input  logic [strb_width(DATA_W)-1:0]   data_wstrb,
  output logic                            data_req_ready,
  output logic [DATA_W-1:0]               data_rdata,
  output logic                            data_rvalid,
  input  logic                            data_rready,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic                            mem_wen,
  output logic                            mem_ren,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [strb_width(DATA_W)-1:0]   mem_wstrb,
  input  logic                            mem_req_ready,
  input  logic [DATA_W-1:0]               mem_rdata,
  input  logic                            mem_rvalid,
  output logic                            mem_rready,
  output logic [31:0]                     perf_conflict
);

  localparam int STRB_W = strb_width(DATA_W);
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [5:0] {
    S_IDLE  = ARB_IDLE,
    S_IREQ  = ARB_IREQ,
    S_IRESP = ARB_IRESP,
    S_DWR   = ARB_DWR,
    S_DRD   = ARB_DRD,
    S_DRESP = ARB_DRESP
  } arb_state_e;

  arb_state_e          state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
  logic [CNT_W-1:0]    starve_reg, starve_next;
  logic [31:0]         perf_reg, perf_next;

  logic data_pend;
  logic fetch_forced;

  assign data_pend    = data_wen | data_ren;
  assign fetch_forced = inst_req_valid && (starve_reg == STARVE_MAX);

  assign mem_addr      = addr_reg;
  assign mem_wdata     = wdata_reg;
  assign mem_wstrb     = wstrb_reg;
  assign perf_conflict = perf_reg;
  // Read data is passed straight through; rvalid alone qualifies it.
  assign inst_rdata    = mem_rdata;
  assign data_rdata    = mem_rdata;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    starve_next    = starve_reg;
    perf_next      = perf_reg;
    inst_req_ready = 1'b0;
    inst_rvalid    = 1'b0;
    data_req_ready = 1'b0;
    data_rvalid    = 1'b0;
    mem_wen        = 1'b0;
    mem_ren        = 1'b0;
    mem_rready     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (data_pend && inst_req_valid) perf_next = perf_reg + 32'd1;
        if (data_pend && !fetch_forced) begin
          addr_next  = data_addr;
          wdata_next = data_wdata;
          wstrb_next = data_wstrb;
          state_next = data_wen ? S_DWR : S_DRD;
          // Not forced with fetch pending means the counter is below its limit.
          if (inst_req_valid) starve_next = starve_reg + CNT_W'(1);
        end else if (inst_req_valid) begin
          addr_next   = inst_addr;
          wdata_next  = '0;
          wstrb_next  = '0;
          state_next  = S_IREQ;
          starve_next = '0;
        end
      end
      S_IREQ: begin
        mem_ren        = 1'b1;
        inst_req_ready = mem_req_ready;
        if (mem_req_ready) state_next = S_IRESP;
      end
      S_IRESP: begin
        inst_rvalid = mem_rvalid;
        mem_rready  = inst_rready;
        if (mem_rvalid && inst_rready) state_next = S_IDLE;
      end
      S_DWR: begin
        mem_wen        = 1'b1;
        data_req_ready = mem_req_ready;
        if (mem_req_ready) state_next = S_IDLE;
      end
      S_DRD: begin
        mem_ren        = 1'b1;
        data_req_ready = mem_req_ready;
        if (mem_req_ready) state_next = S_DRESP;
      end
      S_DRESP: begin
        data_rvalid = mem_rvalid;
        mem_rready  = data_rready;
        if (mem_rvalid && data_rready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
      starve_reg <= '0;
      perf_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      wstrb_reg  <= wstrb_next;
      starve_reg <= starve_next;
      perf_reg   <= perf_next;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_cpu_mem_arbiter;

  localparam int LIM = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        inst_req_valid, inst_req_ready;
  logic [31:0] inst_rdata;
  logic        inst_rvalid, inst_rready;
  logic [31:0] data_addr;
  logic        data_wen, data_ren;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_req_ready;
  logic [31:0] data_rdata;
  logic        data_rvalid, data_rready;
  logic [31:0] mem_addr;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid, mem_rready;
  logic [31:0] perf_conflict;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
    .data_addr(data_addr), .data_wen(data_wen), .data_ren(data_ren),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_req_ready(data_req_ready),
    .data_rdata(data_rdata), .data_rvalid(data_rvalid), .data_rready(data_rready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .perf_conflict(perf_conflict)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_addr = '0; inst_req_valid = 0; inst_rready = 0;
    data_addr = '0; data_wen = 0; data_ren = 0; data_wdata = '0; data_wstrb = '0;
    data_rready = 0; mem_req_ready = 0; mem_rdata = '0; mem_rvalid = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_mem_ren"}, mem_ren, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    chk({tag, "_mem_rready"}, mem_rready, 0);
    chk({tag, "_inst_req_ready"}, inst_req_ready, 0);
    chk({tag, "_data_req_ready"}, data_req_ready, 0);
    chk({tag, "_inst_rvalid"}, inst_rvalid, 0);
    chk({tag, "_data_rvalid"}, data_rvalid, 0);
    chk({tag, "_perf"}, perf_conflict, 0);
  endtask

  // ---------------- directed single-transaction table ----------------
  typedef struct {
    logic        is_inst;
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        e_wen;
    logic        e_ren;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int n, input vec_t v);
    inst_req_valid = v.is_inst; inst_addr = v.addr;
    data_wen = v.wen; data_ren = v.ren; data_addr = v.addr;
    data_wdata = v.wdata; data_wstrb = v.wstrb;
    mem_req_ready = 1; inst_rready = 1; data_rready = 1;
    mem_rvalid = 0; mem_rdata = 32'h0BAD_F00D;
    #1;
    chk("vec_idle_no_memreq", {mem_wen, mem_ren}, 2'b00);
    chk("vec_idle_no_ready", {inst_req_ready, data_req_ready}, 2'b00);
    step();
    chk("vec_mem_wen", mem_wen, v.e_wen);
    chk("vec_mem_ren", mem_ren, v.e_ren);
    chk("vec_mem_addr", mem_addr, v.e_addr);
    chk("vec_mem_wdata", mem_wdata, v.e_wdata);
    chk("vec_mem_wstrb", mem_wstrb, v.e_wstrb);
    chk("vec_inst_req_ready", inst_req_ready, v.is_inst);
    chk("vec_data_req_ready", data_req_ready, !v.is_inst);
    step();
    inst_req_valid = 0; data_wen = 0; data_ren = 0;
    if (v.e_ren) begin
      #1;
      chk("vec_no_early_rvalid", {inst_rvalid, data_rvalid}, 2'b00);
      chk("vec_ren_dropped", mem_ren, 0);
      step();
      mem_rvalid = 1; mem_rdata = v.rdata;
      #1;
      chk("vec_inst_rvalid", inst_rvalid, v.is_inst);
      chk("vec_data_rvalid", data_rvalid, !v.is_inst);
      chk("vec_rdata", v.is_inst ? inst_rdata : data_rdata, v.rdata);
      chk("vec_mem_rready", mem_rready, 1);
      step();
      mem_rvalid = 0;
    end
    #1;
    chk("vec_back_idle", {mem_wen, mem_ren, mem_rready, inst_rvalid, data_rvalid}, 5'b0);
    $display("[TB] vector %0d: %s addr=0x%08h done", n,
             v.is_inst ? "fetch" : (v.e_wen ? "store" : "load"), v.addr);
  endtask

  // ---------------- randomized phase: model state ----------------
  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        own_i;
  } req_t;

  logic [31:0] mem_model[16];
  req_t        exp_q[$];
  logic [31:0] resp_q[$];
  bit          busy_m, rd_pending, rd_own_i, inst_out, data_out;
  int          starve_m, perf_m, n_txn;
  logic [31:0] exp_inst, exp_data;

  logic        s_inst_req_valid, s_inst_req_ready, s_inst_rvalid, s_inst_rready;
  logic        s_data_wen, s_data_ren, s_data_req_ready, s_data_rvalid, s_data_rready;
  logic        s_mem_wen, s_mem_ren, s_mem_req_ready, s_mem_rvalid, s_mem_rready;
  logic [31:0] s_inst_addr, s_data_addr, s_data_wdata, s_mem_addr, s_mem_wdata;
  logic [31:0] s_inst_rdata, s_data_rdata;
  logic [3:0]  s_data_wstrb, s_mem_wstrb;

  function automatic int idx(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  task automatic random_cycle(input bit allow_new);
    bit hs;
    req_t r;
    int i;
    @(negedge clk);
    s_inst_req_valid = inst_req_valid; s_inst_req_ready = inst_req_ready;
    s_inst_rvalid = inst_rvalid; s_inst_rready = inst_rready;
    s_inst_addr = inst_addr; s_inst_rdata = inst_rdata;
    s_data_wen = data_wen; s_data_ren = data_ren; s_data_req_ready = data_req_ready;
    s_data_rvalid = data_rvalid; s_data_rready = data_rready;
    s_data_addr = data_addr; s_data_wdata = data_wdata; s_data_wstrb = data_wstrb;
    s_data_rdata = data_rdata;
    s_mem_wen = mem_wen; s_mem_ren = mem_ren; s_mem_req_ready = mem_req_ready;
    s_mem_rvalid = mem_rvalid; s_mem_rready = mem_rready;
    s_mem_addr = mem_addr; s_mem_wdata = mem_wdata; s_mem_wstrb = mem_wstrb;
    @(posedge clk);
    #1;

    hs = s_mem_req_ready && (s_mem_wen || s_mem_ren);
    chk("rnd_mem_req_active", s_mem_wen | s_mem_ren, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      r = exp_q[0];
      chk("rnd_mem_wen", s_mem_wen, r.wen);
      chk("rnd_mem_ren", s_mem_ren, !r.wen);
      chk("rnd_mem_addr", s_mem_addr, r.addr);
      chk("rnd_mem_wdata", s_mem_wdata, r.wdata);
      chk("rnd_mem_wstrb", s_mem_wstrb, r.strb);
      chk("rnd_inst_req_ready", s_inst_req_ready, hs && r.own_i);
      chk("rnd_data_req_ready", s_data_req_ready, hs && !r.own_i);
    end else begin
      chk("rnd_no_req_ready", {s_inst_req_ready, s_data_req_ready}, 2'b00);
    end
    chk("rnd_mem_rready", s_mem_rready,
        rd_pending && (rd_own_i ? s_inst_rready : s_data_rready));
    chk("rnd_inst_rvalid", s_inst_rvalid, rd_pending && rd_own_i && s_mem_rvalid);
    chk("rnd_data_rvalid", s_data_rvalid, rd_pending && !rd_own_i && s_mem_rvalid);
    if (s_inst_rvalid && s_inst_rready) chk("rnd_inst_rdata", s_inst_rdata, exp_inst);
    if (s_data_rvalid && s_data_rready) chk("rnd_data_rdata", s_data_rdata, exp_data);

    // Arbitration decision taken in an idle cycle; otherwise track completion.
    if (!busy_m) begin
      if (s_inst_req_valid && (s_data_wen || s_data_ren)) perf_m++;
      if ((s_data_wen || s_data_ren) && !(s_inst_req_valid && starve_m == LIM)) begin
        exp_q.push_back('{s_data_wen, s_data_addr, s_data_wdata, s_data_wstrb, 1'b0});
        if (s_inst_req_valid && starve_m < LIM) starve_m++;
        busy_m = 1;
      end else if (s_inst_req_valid) begin
        exp_q.push_back('{1'b0, s_inst_addr, 32'h0, 4'h0, 1'b1});
        starve_m = 0;
        busy_m = 1;
      end
    end else begin
      if (hs && exp_q.size() != 0) begin
        r = exp_q.pop_front();
        n_txn++;
        if (r.wen) begin
          for (i = 0; i < 4; i++)
            if (r.strb[i]) mem_model[idx(r.addr)][8*i +: 8] = r.wdata[8*i +: 8];
          busy_m = 0;
        end else begin
          rd_pending = 1;
          rd_own_i = r.own_i;
          resp_q.push_back(mem_model[idx(r.addr)]);
        end
      end
      if (s_mem_rvalid && s_mem_rready) begin
        if (resp_q.size() != 0) void'(resp_q.pop_front());
        rd_pending = 0;
        busy_m = 0;
      end
    end

    // Requesters
    if (s_inst_req_valid && s_inst_req_ready) begin
      inst_req_valid = 0; inst_out = 1; exp_inst = mem_model[idx(s_inst_addr)];
    end
    if (s_inst_rvalid && s_inst_rready) inst_out = 0;
    if ((s_data_wen || s_data_ren) && s_data_req_ready) begin
      if (!s_data_wen) begin
        data_out = 1; exp_data = mem_model[idx(s_data_addr)];
      end
      data_wen = 0; data_ren = 0;
    end
    if (s_data_rvalid && s_data_rready) data_out = 0;
    if (allow_new && !inst_req_valid && !inst_out && $urandom_range(0, 2) == 0) begin
      inst_req_valid = 1;
      inst_addr = 32'h0000_1000 | (32'($urandom_range(0, 15)) << 2);
    end
    if (allow_new && !(data_wen || data_ren) && !data_out && $urandom_range(0, 2) == 0) begin
      data_wen = $urandom_range(0, 1) == 1;
      data_ren = !data_wen || ($urandom_range(0, 3) == 0);
      data_addr = 32'h0000_2000 | (32'($urandom_range(0, 15)) << 2);
      data_wdata = $urandom;
      data_wstrb = 4'($urandom_range(0, 15));
    end
    inst_rready = $urandom_range(0, 3) != 0;
    data_rready = $urandom_range(0, 3) != 0;

    // Memory device
    if (s_mem_rvalid && s_mem_rready) mem_rvalid = 0;
    mem_req_ready = $urandom_range(0, 2) != 0;
    if (!mem_rvalid) begin
      if (resp_q.size() != 0 && $urandom_range(0, 1) == 1) begin
        mem_rvalid = 1; mem_rdata = resp_q[0];
      end else begin
        mem_rdata = $urandom;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  g;
    bit  seq[6];
    bit  stuck;

    rst = 1'b1;
    clear_inputs();
    do_reset();
    #1;
    chk_all_zero("reset");

    //          inst wen ren addr          wdata         strb   rdata         ewen eren eaddr         ewdata        estrb
    vecs[0] = '{1, 0, 0, 32'h0000_0100, 32'h1234_5678, 4'hF, 32'h0050_0093, 0, 1, 32'h0000_0100, 32'h0,        4'h0};
    vecs[1] = '{0, 1, 0, 32'h0000_2004, 32'hDEAD_BEEF, 4'h3, 32'h0,        1, 0, 32'h0000_2004, 32'hDEAD_BEEF, 4'h3};
    vecs[2] = '{0, 0, 1, 32'h0000_3000, 32'h1111_1111, 4'hF, 32'hCAFE_F00D, 0, 1, 32'h0000_3000, 32'h1111_1111, 4'hF};
    vecs[3] = '{0, 1, 1, 32'h0000_0044, 32'hA5A5_A5A5, 4'hC, 32'h0,        1, 0, 32'h0000_0044, 32'hA5A5_A5A5, 4'hC};
    vecs[4] = '{1, 0, 0, 32'hFFFF_FFFC, 32'h0,        4'h0, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFC, 32'h0,        4'h0};
    for (int n = 0; n < 5; n++) run_vec(n, vecs[n]);
    chk("vec_no_conflicts", perf_conflict, 0);

    // Simultaneous fetch and load: load first, then fetch, one conflict cycle.
    do_reset();
    inst_req_valid = 1; inst_addr = 32'h40;
    data_ren = 1; data_addr = 32'h3000;
    mem_req_ready = 1; inst_rready = 1; data_rready = 1;
    #1;
    chk("conf_perf_before", perf_conflict, 0);
    step();
    chk("conf_first_ren", mem_ren, 1);
    chk("conf_first_addr", mem_addr, 32'h3000);
    chk("conf_first_data_ready", data_req_ready, 1);
    chk("conf_first_inst_ready", inst_req_ready, 0);
    chk("conf_perf_one", perf_conflict, 1);
    step();
    data_ren = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    #1;
    chk("conf_load_rvalid", {data_rvalid, inst_rvalid}, 2'b10);
    step();
    mem_rvalid = 0;
    step();
    chk("conf_second_addr", mem_addr, 32'h40);
    chk("conf_second_inst_ready", inst_req_ready, 1);
    chk("conf_perf_still_one", perf_conflict, 1);
    step();
    inst_req_valid = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    #1;
    chk("conf_fetch_rvalid", inst_rvalid, 1);
    chk("conf_fetch_rdata", inst_rdata, 32'h0050_0093);
    $display("[TB] sequence conflict: load then fetch done");

    // Reset while in the fetch response state, then a stray rvalid in idle.
    rst = 1;
    step();
    chk_all_zero("rst_iresp");
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stray_inst_rvalid", inst_rvalid, 0);
      chk("stray_data_rvalid", data_rvalid, 0);
      chk("stray_mem_rready", mem_rready, 0);
      step();
    end
    mem_rvalid = 0;
    $display("[TB] sequence reset-in-response done");

    // Starvation: continuous stores with fetch held -> D,D,I,D,D,I.
    do_reset();
    data_wen = 1; data_addr = 32'h500; data_wdata = 32'h5555_AAAA; data_wstrb = 4'hF;
    inst_req_valid = 1; inst_addr = 32'h600;
    mem_req_ready = 1; mem_rvalid = 1; mem_rdata = 32'h0000_0001; inst_rready = 1;
    seq = '{0, 0, 1, 0, 0, 1};
    g = 0;
    for (int c = 0; c < 40 && g < 6; c++) begin
      #1;
      if (mem_wen || mem_ren) begin
        chk("starve_grant_is_fetch", mem_ren, seq[g]);
        if (g == 5) chk("starve_perf", perf_conflict, 6);
        g++;
      end
      step();
    end
    chk("starve_grant_count", g, 6);
    clear_inputs();
    $display("[TB] sequence starvation: %0d grants observed", g);

    // Backpressure on request and on response.
    do_reset();
    data_ren = 1; data_addr = 32'h80; data_wdata = 32'h77; data_wstrb = 4'hF;
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ren_held", mem_ren, 1);
      chk("bp_addr_stable", mem_addr, 32'h80);
      chk("bp_wdata_stable", mem_wdata, 32'h77);
      chk("bp_no_ready", data_req_ready, 0);
      chk("bp_no_rready", mem_rready, 0);
      data_addr = 32'h0000_FFF0;
      data_wdata = 32'h0;
      step();
    end
    mem_req_ready = 1;
    #1;
    chk("bp_ready_pulse", data_req_ready, 1);
    chk("bp_addr_final", mem_addr, 32'h80);
    step();
    data_ren = 0; mem_req_ready = 0;
    mem_rvalid = 1; mem_rdata = 32'hABCD_1234; data_rready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rvalid_held", data_rvalid, 1);
      chk("bp_rdata", data_rdata, 32'hABCD_1234);
      chk("bp_rready_low", mem_rready, 0);
      chk("bp_ren_low", mem_ren, 0);
      step();
    end
    data_rready = 1;
    #1;
    chk("bp_rready_high", mem_rready, 1);
    step();
    mem_rvalid = 0;
    #1;
    chk("bp_idle_rready", mem_rready, 0);
    chk("bp_idle_rvalid", data_rvalid, 0);
    $display("[TB] sequence backpressure done");

    // Randomized traffic against the transaction model.
    do_reset();
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    exp_q.delete(); resp_q.delete();
    busy_m = 0; rd_pending = 0; rd_own_i = 0; inst_out = 0; data_out = 0;
    starve_m = 0; perf_m = 0; n_txn = 0;
    for (int c = 0; c < 3000; c++) random_cycle(1'b1);
    stuck = 1;
    for (int c = 0; c < 300; c++) begin
      if (!busy_m && !inst_req_valid && !data_wen && !data_ren && !inst_out && !data_out
          && !mem_rvalid) begin
        stuck = 0;
        break;
      end
      random_cycle(1'b0);
    end
    chk("rnd_drain_timeout", stuck, 0);
    chk("rnd_perf_conflict", perf_conflict, perf_m);
    chk("rnd_enough_traffic", n_txn > 100, 1);
    $display("[TB] random phase: %0d memory transactions, %0d conflict cycles", n_txn, perf_m);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
